// File: rtl/accum_bank_pkg.sv
// accum_bank_pkg
//   Shared types and constants for the accumulator bank.
//   - fsm_e          : clear-all sequencer states
//   - sat_max/sat_min: saturation limits for a given accumulator width and
//                      signedness, returned right-aligned in a MAX_W-bit
//                      word (callers slice the low WIDTH bits).
package accum_bank_pkg;

    // Widest accumulator the saturation helpers can describe.
    localparam int MAX_W = 64;

    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } fsm_e;

    // Largest representable value: 2^w-1 unsigned, 2^(w-1)-1 signed.
    function automatic logic [MAX_W-1:0] sat_max(input int width, input bit is_signed);
        logic [MAX_W-1:0] ones;
        ones = '1;
        return is_signed ? (ones >> (MAX_W - width + 1)) : (ones >> (MAX_W - width));
    endfunction

    // Smallest representable value: -2^(w-1) signed, 0 unsigned.
    function automatic logic [MAX_W-1:0] sat_min(input int width, input bit is_signed);
        logic [MAX_W-1:0] one;
        one = MAX_W'(1);
        return is_signed ? (one << (width - 1)) : '0;
    endfunction

endpackage

// File: rtl/accum_sat_add.sv
// accum_sat_add
//   Combinational extend + add + overflow detect, with optional clamp.
//   Ports:
//     i_sum    [WIDTH-1:0]     current running sum
//     i_amt    [IN_WIDTH-1:0]  addend (sign- or zero-extended per SIGNED)
//     o_result [WIDTH-1:0]     wrapped or clamped new sum
//     o_ovf                    this addition overflowed
module accum_sat_add
    import accum_bank_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int IN_WIDTH = 16,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0]    i_sum,
    input  logic [IN_WIDTH-1:0] i_amt,
    output logic [WIDTH-1:0]    o_result,
    output logic                o_ovf
);

    localparam logic [MAX_W-1:0] MAX_FULL = sat_max(WIDTH, SIGNED != 0);
    localparam logic [MAX_W-1:0] MIN_FULL = sat_min(WIDTH, SIGNED != 0);
    localparam logic [WIDTH-1:0] SAT_HI   = MAX_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SAT_LO   = MIN_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] w_ext;
    logic [WIDTH:0]   w_full;
    logic             w_ovf;

    generate
        if (IN_WIDTH == WIDTH) begin : g_no_ext
            assign w_ext = i_amt;
        end else begin : g_ext
            logic w_fill;
            assign w_fill = (SIGNED != 0) ? i_amt[IN_WIDTH-1] : 1'b0;
            assign w_ext  = {{(WIDTH-IN_WIDTH){w_fill}}, i_amt};
        end
    endgenerate

    // One extra bit keeps the unsigned carry out.
    assign w_full = {1'b0, i_sum} + {1'b0, w_ext};

    always_comb begin
        // Signed: same-sign operands producing an opposite-sign result.
        // Unsigned: carry out of the top bit.
        if (SIGNED != 0)
            w_ovf = (i_sum[WIDTH-1] == w_ext[WIDTH-1]) && (w_full[WIDTH-1] != i_sum[WIDTH-1]);
        else
            w_ovf = w_full[WIDTH];

        o_ovf    = w_ovf;
        o_result = w_full[WIDTH-1:0];
        if ((SATURATE != 0) && w_ovf) begin
            // Signed overflow direction follows the (shared) operand sign.
            if ((SIGNED != 0) && i_sum[WIDTH-1])
                o_result = SAT_LO;
            else
                o_result = SAT_HI;
        end
    end

endmodule

// File: rtl/accum_bank.sv
// accum_bank
//   CHANNELS independent WIDTH-bit running sums fed one addend per cycle,
//   with a registered read port (optional clear-on-read), sticky per-channel
//   overflow and a one-channel-per-cycle clear-all sequence.
//   Ports:
//     clk, reset          clock (rising edge), async active-high reset
//     in_valid/in_ready   addend handshake; in_ready low only while clearing
//     in_ch, in_amt       target channel and addend
//     clr_all             pulse to start the clear-all sequence
//     rd_req, rd_ch       read request (taken only when in_ready=1)
//     rd_valid            one-cycle pulse, rd_sum/rd_ovf valid
//     rd_sum, rd_ovf      read channel's sum and sticky overflow
//     ovf_flags           live sticky overflow flags
//     busy                clear-all in progress (~in_ready)
module accum_bank
    import accum_bank_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IN_WIDTH  = 16,
    parameter int CHANNELS  = 4,
    parameter int SIGNED    = 0,
    parameter int SATURATE  = 0,
    parameter int CLR_ON_RD = 0,
    localparam int CH_W     = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH_W-1:0]     in_ch,
    input  logic [IN_WIDTH-1:0] in_amt,
    input  logic                clr_all,
    input  logic                rd_req,
    input  logic [CH_W-1:0]     rd_ch,
    output logic                rd_valid,
    output logic [WIDTH-1:0]    rd_sum,
    output logic                rd_ovf,
    output logic [CHANNELS-1:0] ovf_flags,
    output logic                busy
);

    localparam logic [CH_W:0]   CH_LIM  = (CH_W+1)'(CHANNELS);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);

    fsm_e                            r_state;
    logic [CH_W-1:0]                 r_clr_idx;
    logic [CHANNELS-1:0][WIDTH-1:0]  r_sum;
    logic [CHANNELS-1:0]             r_ovf;
    logic                            r_rd_valid;
    logic [WIDTH-1:0]                r_rd_sum;
    logic                            r_rd_ovf;

    logic             w_ready;
    logic             w_in_ok;
    logic             w_rd_ok;
    logic             w_acc;
    logic             w_rd_acc;
    logic             w_clr_hit;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_result;
    logic             w_add_ovf;
    logic             w_new_ovf;

    assign w_ready  = (r_state == IDLE);
    assign w_in_ok  = ({1'b0, in_ch} < CH_LIM);
    assign w_rd_ok  = ({1'b0, rd_ch} < CH_LIM);
    // Out-of-range addends complete the handshake but touch nothing.
    assign w_acc    = in_valid && w_ready && w_in_ok;
    assign w_rd_acc = rd_req && w_ready;

    // Clear-on-read racing an addend to the same channel: the addend starts
    // from zero, so it cannot overflow and the old flag is discarded.
    assign w_clr_hit = (CLR_ON_RD != 0) && w_rd_acc && w_rd_ok && (rd_ch == in_ch);
    assign w_base    = w_clr_hit ? '0 : r_sum[in_ch];

    accum_sat_add #(
        .WIDTH    (WIDTH),
        .IN_WIDTH (IN_WIDTH),
        .SIGNED   (SIGNED),
        .SATURATE (SATURATE)
    ) u_add (
        .i_sum    (w_base),
        .i_amt    (in_amt),
        .o_result (w_result),
        .o_ovf    (w_add_ovf)
    );

    assign w_new_ovf = w_clr_hit ? w_add_ovf : (r_ovf[in_ch] | w_add_ovf);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_clr_idx  <= '0;
            r_sum      <= '0;
            r_ovf      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_sum   <= '0;
            r_rd_ovf   <= 1'b0;
        end else begin
            // Read port samples storage before this cycle's writes land.
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_sum <= w_rd_ok ? r_sum[rd_ch] : '0;
                r_rd_ovf <= w_rd_ok ? r_ovf[rd_ch] : 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (clr_all) begin
                        r_state   <= CLEARING;
                        r_clr_idx <= '0;
                    end
                end
                CLEARING: begin
                    r_sum[r_clr_idx] <= '0;
                    r_ovf[r_clr_idx] <= 1'b0;
                    if (r_clr_idx == CH_LAST) begin
                        r_state   <= IDLE;
                        r_clr_idx <= '0;
                    end else begin
                        r_clr_idx <= r_clr_idx + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Reads and addends only happen in IDLE, so they never race the
            // clear sequence. The addend write comes last so it wins over a
            // same-channel clear-on-read.
            if ((CLR_ON_RD != 0) && w_rd_acc && w_rd_ok) begin
                r_sum[rd_ch] <= '0;
                r_ovf[rd_ch] <= 1'b0;
            end
            if (w_acc) begin
                r_sum[in_ch] <= w_result;
                r_ovf[in_ch] <= w_new_ovf;
            end
        end
    end

    assign in_ready  = w_ready;
    assign busy      = ~w_ready;
    assign rd_valid  = r_rd_valid;
    assign rd_sum    = r_rd_sum;
    assign rd_ovf    = r_rd_ovf;
    assign ovf_flags = r_ovf;

endmodule

// File: tb/tb_accum_bank.sv
// Bench for accum_bank: five instances cover default, 8-bit wrap, 8-bit
// saturate, 8-bit signed saturate and clear-on-read. Inputs change on the
// falling edge; outputs are sampled on the falling edge after the capture.
module tb_accum_bank;

    localparam int N = 5;

    logic clk;
    logic reset;

    logic        iv   [N];
    logic [1:0]  ich  [N];
    logic [15:0] amt  [N];
    logic        clr  [N];
    logic        rq   [N];
    logic [1:0]  rch  [N];
    logic        irdy [N];
    logic        rv   [N];
    logic        rovf [N];
    logic        bsy  [N];
    logic [3:0]  ovff [N];

    logic [31:0] rs0, rs4;
    logic [7:0]  rs1, rs2, rs3;

    typedef struct {
        int          k;
        logic [31:0] sum;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_chk;
    int   n_fail;

    accum_bank #(.WIDTH(32), .IN_WIDTH(16), .CHANNELS(4)) u0 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(irdy[0]), .in_ch(ich[0]),
        .in_amt(amt[0]), .clr_all(clr[0]), .rd_req(rq[0]), .rd_ch(rch[0]), .rd_valid(rv[0]),
        .rd_sum(rs0), .rd_ovf(rovf[0]), .ovf_flags(ovff[0]), .busy(bsy[0]));

    accum_bank #(.WIDTH(8), .IN_WIDTH(8), .CHANNELS(4), .SATURATE(0)) u1 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(irdy[1]), .in_ch(ich[1]),
        .in_amt(amt[1][7:0]), .clr_all(clr[1]), .rd_req(rq[1]), .rd_ch(rch[1]), .rd_valid(rv[1]),
        .rd_sum(rs1), .rd_ovf(rovf[1]), .ovf_flags(ovff[1]), .busy(bsy[1]));

    accum_bank #(.WIDTH(8), .IN_WIDTH(8), .CHANNELS(4), .SATURATE(1)) u2 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(irdy[2]), .in_ch(ich[2]),
        .in_amt(amt[2][7:0]), .clr_all(clr[2]), .rd_req(rq[2]), .rd_ch(rch[2]), .rd_valid(rv[2]),
        .rd_sum(rs2), .rd_ovf(rovf[2]), .ovf_flags(ovff[2]), .busy(bsy[2]));

    accum_bank #(.WIDTH(8), .IN_WIDTH(8), .CHANNELS(4), .SIGNED(1), .SATURATE(1)) u3 (
        .clk(clk), .reset(reset), .in_valid(iv[3]), .in_ready(irdy[3]), .in_ch(ich[3]),
        .in_amt(amt[3][7:0]), .clr_all(clr[3]), .rd_req(rq[3]), .rd_ch(rch[3]), .rd_valid(rv[3]),
        .rd_sum(rs3), .rd_ovf(rovf[3]), .ovf_flags(ovff[3]), .busy(bsy[3]));

    accum_bank #(.WIDTH(32), .IN_WIDTH(16), .CHANNELS(4), .CLR_ON_RD(1)) u4 (
        .clk(clk), .reset(reset), .in_valid(iv[4]), .in_ready(irdy[4]), .in_ch(ich[4]),
        .in_amt(amt[4]), .clr_all(clr[4]), .rd_req(rq[4]), .rd_ch(rch[4]), .rd_valid(rv[4]),
        .rd_sum(rs4), .rd_ovf(rovf[4]), .ovf_flags(ovff[4]), .busy(bsy[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1);
    end

    function automatic logic [31:0] obs(input int k);
        case (k)
            0:       return rs0;
            1:       return {24'h0, rs1};
            2:       return {24'h0, rs2};
            3:       return {24'h0, rs3};
            default: return rs4;
        endcase
    endfunction

    // Stimulus: one addend, held for one cycle. Entered and left on a negedge.
    task automatic acc(input int k, input int ch, input logic [15:0] a);
        iv[k] = 1'b1; ich[k] = 2'(ch); amt[k] = a;
        @(negedge clk);
        iv[k] = 1'b0;
    endtask

    // Stimulus: one read request; the expected response goes to the scoreboard.
    task automatic rd(input int k, input int ch, input logic [31:0] es, input logic eo);
        sb.push_back('{k, es, eo});
        rq[k] = 1'b1; rch[k] = 2'(ch);
        @(negedge clk);
        rq[k] = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (irdy[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: in_ready=%0b busy=%0b, expected 1/0", irdy[0], bsy[0]);
        end
        n_chk++;
        if (rv[0] !== 1'b0 || rs0 !== 32'h0 || rovf[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_read: rd_valid=%0b rd_sum=%0h rd_ovf=%0b, expected 0/0/0", rv[0], rs0, rovf[0]);
        end
        n_chk++;
        if (ovff[0] !== 4'h0 || ovff[3] !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_ovf: flags=%0h/%0h, expected 0/0", ovff[0], ovff[3]);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_accum;
        acc(0, 2, 16'd100);
        acc(0, 2, 16'd200);
        acc(0, 2, 16'd300);
        rd(0, 2, 32'd600, 1'b0);
        e = sb.pop_front();
        n_chk++;
        if (rv[e.k] !== 1'b1 || obs(e.k) !== e.sum || rovf[e.k] !== e.ovf) begin
            n_fail++;
            $display("FAIL accum_ch2: valid=%0b sum=%0d ovf=%0b, expected 1/%0d/%0b", rv[e.k], obs(e.k), rovf[e.k], e.sum, e.ovf);
        end
        @(negedge clk);
        n_chk++;
        if (rv[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_valid_pulse: rd_valid=%0b two cycles after rd_req, expected 0", rv[0]);
        end
        for (int c = 0; c < 4; c++) begin
            if (c == 2) continue;
            rd(0, c, 32'd0, 1'b0);
            e = sb.pop_front();
            n_chk++;
            if (rv[e.k] !== 1'b1 || obs(e.k) !== e.sum || rovf[e.k] !== e.ovf) begin
                n_fail++;
                $display("FAIL accum_other_ch%0d: valid=%0b sum=%0d ovf=%0b, expected 1/%0d/%0b", c, rv[e.k], obs(e.k), rovf[e.k], e.sum, e.ovf);
            end
        end
    endtask

    task automatic test_back_to_back;
        // Same-cycle read and addend to channel 2: read sees the old value.
        sb.push_back('{0, 32'd600, 1'b0});
        iv[0] = 1'b1; ich[0] = 2'd2; amt[0] = 16'd5;
        rq[0] = 1'b1; rch[0] = 2'd2;
        @(negedge clk);
        iv[0] = 1'b0; rq[0] = 1'b0;
        e = sb.pop_front();
        n_chk++;
        if (rv[e.k] !== 1'b1 || obs(e.k) !== e.sum || rovf[e.k] !== e.ovf) begin
            n_fail++;
            $display("FAIL read_before_write: valid=%0b sum=%0d ovf=%0b, expected 1/%0d/%0b", rv[e.k], obs(e.k), rovf[e.k], e.sum, e.ovf);
        end
        rd(0, 2, 32'd605, 1'b0);
        e = sb.pop_front();
        n_chk++;
        if (rv[e.k] !== 1'b1 || obs(e.k) !== e.sum || rovf[e.k] !== e.ovf) begin
            n_fail++;
            $display("FAIL write_applied: valid=%0b sum=%0d ovf=%0b, expected 1/%0d/%0b", rv[e.k], obs(e.k), rovf[e.k], e.sum, e.ovf);
        end
    endtask

    task automatic test_overflow;
        // 200 + 100 on 8 bits: wrap to 44 on u1, clamp to 255 on u2.
        acc(1, 0, 16'd200);
        acc(1, 0, 16'd100);
        acc(2, 0, 16'd200);
        acc(2, 0, 16'd100);
        n_chk++;
        if (ovff[1] !== 4'b0001 || ovff[2] !== 4'b0001) begin
            n_fail++;
            $display("FAIL ovf_flags_unsigned: wrap=%04b sat=%04b, expected 0001/0001", ovff[1], ovff[2]);
        end
        rd(1, 0, 32'd44, 1'b1);
        rd(2, 0, 32'd255, 1'b1);
        // Both reads return on consecutive cycles; compare the second first
        // sample is gone, so the wrap read was captured into rs1 and held.
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            n_chk++;
            if (obs(e.k) !== e.sum || rovf[e.k] !== e.ovf) begin
                n_fail++;
                $display("FAIL unsigned_ovf_u%0d: sum=%0d ovf=%0b, expected %0d/%0b", e.k, obs(e.k), rovf[e.k], e.sum, e.ovf);
            end
        end
        n_chk++;
        if (rv[2] !== 1'b1 || rv[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL unsigned_ovf_valid: u1=%0b u2=%0b, expected 0/1", rv[1], rv[2]);
        end
    endtask

    task automatic test_signed_sat;
        acc(3, 1, 16'h009C);  // -100
        acc(3, 1, 16'h009C);  // -100 -> clamps at -128
        rd(3, 1, 32'h80, 1'b1);
        e = sb.pop_front();
        n_chk++;
        if (rv[e.k] !== 1'b1 || obs(e.k) !== e.sum || rovf[e.k] !== e.ovf) begin
            n_fail++;
            $display("FAIL signed_min: valid=%0b sum=%0h ovf=%0b, expected 1/%0h/%0b", rv[e.k], obs(e.k), rovf[e.k], e.sum, e.ovf);
        end
        acc(3, 1, 16'h007F);  // +127 -> -1, flag stays set
        rd(3, 1, 32'hFF, 1'b1);
        e = sb.pop_front();
        n_chk++;
        if (rv[e.k] !== 1'b1 || obs(e.k) !== e.sum || rovf[e.k] !== e.ovf) begin
            n_fail++;
            $display("FAIL signed_sticky: valid=%0b sum=%0h ovf=%0b, expected 1/%0h/%0b", rv[e.k], obs(e.k), rovf[e.k], e.sum, e.ovf);
        end
        n_chk++;
        if (ovff[3] !== 4'b0010) begin
            n_fail++;
            $display("FAIL signed_flags: flags=%04b, expected 0010", ovff[3]);
        end
    endtask

    task automatic test_clr_on_rd;
        acc(4, 3, 16'd50);
        sb.push_back('{4, 32'd50, 1'b0});
        iv[4] = 1'b1; ich[4] = 2'd3; amt[4] = 16'd7;
        rq[4] = 1'b1; rch[4] = 2'd3;
        @(negedge clk);
        iv[4] = 1'b0; rq[4] = 1'b0;
        e = sb.pop_front();
        n_chk++;
        if (rv[e.k] !== 1'b1 || obs(e.k) !== e.sum || rovf[e.k] !== e.ovf) begin
            n_fail++;
            $display("FAIL clr_on_rd_first: valid=%0b sum=%0d ovf=%0b, expected 1/%0d/%0b", rv[e.k], obs(e.k), rovf[e.k], e.sum, e.ovf);
        end
        rd(4, 3, 32'd7, 1'b0);
        e = sb.pop_front();
        n_chk++;
        if (rv[e.k] !== 1'b1 || obs(e.k) !== e.sum || rovf[e.k] !== e.ovf) begin
            n_fail++;
            $display("FAIL clr_on_rd_second: valid=%0b sum=%0d ovf=%0b, expected 1/%0d/%0b", rv[e.k], obs(e.k), rovf[e.k], e.sum, e.ovf);
        end
        rd(4, 3, 32'd0, 1'b0);
        e = sb.pop_front();
        n_chk++;
        if (rv[e.k] !== 1'b1 || obs(e.k) !== e.sum || rovf[e.k] !== e.ovf) begin
            n_fail++;
            $display("FAIL clr_on_rd_third: valid=%0b sum=%0d ovf=%0b, expected 1/%0d/%0b", rv[e.k], obs(e.k), rovf[e.k], e.sum, e.ovf);
        end
    endtask

    task automatic test_clear_all;
        for (int c = 0; c < 4; c++) acc(1, c, 16'(10 + c));
        clr[1] = 1'b1;
        @(negedge clk);
        clr[1] = 0;
        // Hammer the ports for the whole clear window; nothing may land.
        rq[1] = 1'b1; rch[1] = 2'd1;
        iv[1] = 1'b1; ich[1] = 2'd1; amt[1] = 16'd5;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (irdy[1] !== 1'b0 || bsy[1] !== 1'b1 || rv[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_window_%0d: in_ready=%0b busy=%0b rd_valid=%0b, expected 0/1/0", i, irdy[1], bsy[1], rv[1]);
            end
            @(negedge clk);
        end
        n_chk++;
        if (irdy[1] !== 1'b1 || bsy[1] !== 1'b0 || rv[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_done: in_ready=%0b busy=%0b rd_valid=%0b, expected 1/0/0", irdy[1], bsy[1], rv[1]);
        end
        rq[1] = 1'b0; iv[1] = 1'b0;
        n_chk++;
        if (ovff[1] !== 4'h0) begin
            n_fail++;
            $display("FAIL clear_flags: flags=%04b, expected 0000", ovff[1]);
        end
        for (int c = 0; c < 4; c++) begin
            rd(1, c, 32'd0, 1'b0);
            e = sb.pop_front();
            n_chk++;
            if (rv[e.k] !== 1'b1 || obs(e.k) !== e.sum || rovf[e.k] !== e.ovf) begin
                n_fail++;
                $display("FAIL clear_ch%0d: valid=%0b sum=%0d ovf=%0b, expected 1/%0d/%0b", c, rv[e.k], obs(e.k), rovf[e.k], e.sum, e.ovf);
            end
        end
    endtask

    task automatic test_reset_mid;
        // Mid-read: rd_valid is high, then reset lands between edges.
        rq[0] = 1'b1; rch[0] = 2'd2;
        @(posedge clk);
        #2;
        rq[0] = 1'b0;
        n_chk++;
        if (rv[0] !== 1'b1 || rs0 !== 32'd605) begin
            n_fail++;
            $display("FAIL pre_reset_read: valid=%0b sum=%0d, expected 1/605", rv[0], rs0);
        end
        reset = 1'b1;
        #1;
        n_chk++;
        if (rv[0] !== 1'b0 || rs0 !== 32'd0 || rovf[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_read: valid=%0b sum=%0d ovf=%0b, expected 0/0/0", rv[0], rs0, rovf[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        // Mid-clear: two cycles into the sequence.
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        @(negedge clk);
        n_chk++;
        if (irdy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_clear_busy: in_ready=%0b, expected 0", irdy[0]);
        end
        #2;
        reset = 1'b1;
        #1;
        n_chk++;
        if (irdy[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: in_ready=%0b busy=%0b, expected 1/0", irdy[0], bsy[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        acc(0, 1, 16'd9);
        rd(0, 1, 32'd9, 1'b0);
        e = sb.pop_front();
        n_chk++;
        if (rv[e.k] !== 1'b1 || obs(e.k) !== e.sum || rovf[e.k] !== e.ovf) begin
            n_fail++;
            $display("FAIL post_reset_acc: valid=%0b sum=%0d ovf=%0b, expected 1/%0d/%0b", rv[e.k], obs(e.k), rovf[e.k], e.sum, e.ovf);
        end
        rd(0, 2, 32'd0, 1'b0);
        e = sb.pop_front();
        n_chk++;
        if (rv[e.k] !== 1'b1 || obs(e.k) !== e.sum || rovf[e.k] !== e.ovf) begin
            n_fail++;
            $display("FAIL post_reset_ch2: valid=%0b sum=%0d ovf=%0b, expected 1/%0d/%0b", rv[e.k], obs(e.k), rovf[e.k], e.sum, e.ovf);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        for (int k = 0; k < N; k++) begin
            iv[k] = 1'b0; ich[k] = '0; amt[k] = '0;
            clr[k] = 1'b0; rq[k] = 1'b0; rch[k] = '0;
        end
        test_reset();
        test_accum();
        test_back_to_back();
        test_overflow();
        test_signed_sat();
        test_clr_on_rd();
        test_clear_all();
        test_reset_mid();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
